// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage (master) and the iterative divider (slave).
// Handshake: master raises start_i with operands and holds it until it sees ready_o; the
// divider keeps ready_o/result_o stable while start_i stays high, and clears both once it drops.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic [1:0]           state_dbg;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, state_dbg
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, state_dbg
    );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, result {rem, quo}.
// Optional DIV_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     dvd;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     dsr;
    logic                 neg_q;
    logic                 neg_r;
    logic                 ready_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]     in_mag_a;
    logic [WIDTH-1:0]     in_mag_b;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_sub;
    logic                 ge;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     dvd_nx;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;

    // Magnitudes of the incoming operands; -MIN stays MIN, which reads correctly as unsigned.
    always_comb begin
        in_mag_a = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
        in_mag_b = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    end

    // The shifted partial remainder needs one extra bit before the compare.
    always_comb begin
        rem_sh  = {rem, dvd[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dsr};
        ge      = (rem_sh >= {1'b0, dsr});
        rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx  = {dvd[WIDTH-2:0], ge};
        q_fix   = neg_q ? -dvd_nx : dvd_nx;
        r_fix   = neg_r ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dvd      <= '0;
            rem      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        dsr   <= in_mag_b;
                        dvd   <= in_mag_a;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= bus.signed_div_i &
                                 (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        neg_r <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                        if (bus.opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (in_mag_a < in_mag_b) begin
                            // Quotient is zero and the dividend itself is the remainder.
                            state    <= S_END;
                            ready_q  <= 1'b1;
                            result_q <= {bus.opdata1_i, {WIDTH{1'b0}}};
                        end
`endif
                        else begin
                            state <= S_ON;
                        end
                    end
                end
                S_BYZERO: begin
                    if (bus.annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        state    <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= '0;
                    end
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state    <= S_END;
                            ready_q  <= 1'b1;
                            result_q <= {r_fix, q_fix};
                        end
                    end
                end
                S_END: begin
                    if (!bus.start_i) begin
                        state    <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.result_o  = result_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed divisions against a transaction-level model plus literal results.
// Define DIV_EARLY_EXIT_EN on both bench and RTL to check the early-exit build.
module tb_div_seq;
    localparam int W = 32;

    logic clk;
    logic rst;
    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] a, input bit s);
        return (s && a[31]) ? 32'(-a) : a;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        if (mag(a, s) < mag(b, s)) return 1;
`endif
        return W + 1;
    endfunction

    // ---------------- transaction model ----------------
    // Tracks one outstanding request: edges left until ready, then the held result.
    bit          m_pending = 1'b0;
    bit          m_hold    = 1'b0;
    int          m_left    = 0;
    logic [63:0] m_res     = 64'd0;
    logic [63:0] m_next    = 64'd0;

    always @(posedge clk) begin
        if (!rst) begin
            m_pending = 1'b0;
            m_hold    = 1'b0;
            m_res     = 64'd0;
        end else if (m_hold) begin
            if (!bus.start_i) begin
                m_hold = 1'b0;
                m_res  = 64'd0;
            end
        end else if (m_pending) begin
            if (bus.annul_i) begin
                m_pending = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_pending = 1'b0;
                    m_hold    = 1'b1;
                    m_res     = m_next;
                end
            end
        end else if (bus.start_i && !bus.annul_i) begin
            m_next = ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
            m_left = ref_lat(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i) - 1;
            if (m_left == 0) begin
                m_hold = 1'b1;
                m_res  = m_next;
            end else begin
                m_pending = 1'b1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ready", {63'd0, bus.ready_o}, {63'd0, m_hold});
            chk("model_result", bus.result_o, m_res);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input bit s, input logic [63:0] exp_lit, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.start_i      = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            // Operands are latched at accept; later changes must not matter.
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
        end while (!bus.ready_o && lat < 60);
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_res"}, bus.result_o, exp_lit);
        // Result must hold while start stays high, even with a flush pulse.
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        chk({nm, "_hold"}, bus.result_o, exp_lit);
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({nm, "_drop"}, {63'd0, bus.ready_o}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    int early_lat;

    initial begin
`ifdef DIV_EARLY_EXIT_EN
        early_lat = 1;
`else
        early_lat = W + 1;
`endif
        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        idle_cycles(3);
        chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_state", {62'd0, bus.state_dbg}, 64'd0);
        rst    = 1'b1;
        cmp_en = 1'b1;
        idle_cycles(2);

        run_div("divu_100_7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 W + 1);
        run_div("div_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, W + 1);
        run_div("div_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD},         W + 1);
        run_div("div_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000},         W + 1);
        run_div("divu_5_0",     32'd5,          32'd0,          1'b0, 64'd0,                           2);
        run_div("divu_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF},         W + 1);
        run_div("div_m100_m7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'd14},        W + 1);
        run_div("divu_big_2",   32'hFFFF_FFF9,  32'd2,          1'b0, {32'd1, 32'h7FFF_FFFC},         W + 1);
        run_div("divu_3_10",    32'd3,          32'd10,         1'b0, {32'd3, 32'd0},                 early_lat);
        run_div("div_m3_10",    32'hFFFF_FFFD,  32'd10,         1'b1, {32'hFFFF_FFFD, 32'd0},         early_lat);
        run_div("div_0_5",      32'd0,          32'd5,          1'b1, 64'd0,                           early_lat);
        run_div("div_m1_0",     32'hFFFF_FFFF,  32'd0,          1'b1, 64'd0,                           2);

        // Flush mid-iteration, then a fresh request two cycles later.
        @(negedge clk);
        bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0; bus.start_i = 1'b1;
        idle_cycles(10);
        bus.annul_i = 1'b1; bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        chk("annul_on_state", {62'd0, bus.state_dbg}, 64'd0);
        run_div("after_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, W + 1);
        idle_cycles(3);

        // Flush during the divide-by-zero step.
        @(negedge clk);
        bus.opdata1_i = 32'd5; bus.opdata2_i = 32'd0; bus.start_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b1; bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        chk("annul_byzero_state", {62'd0, bus.state_dbg}, 64'd0);
        idle_cycles(4);

        // Synchronous reset in the middle of an iteration.
        @(negedge clk);
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.start_i = 1'b1;
        idle_cycles(5);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_on_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        chk("rst_on_state", {62'd0, bus.state_dbg}, 64'd0);
        rst = 1'b1; bus.start_i = 1'b0;
        idle_cycles(W + 6);

        // Start blocked by a simultaneous flush.
        @(negedge clk);
        bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5; bus.start_i = 1'b1; bus.annul_i = 1'b1;
        idle_cycles(3);
        chk("annul_idle_state", {62'd0, bus.state_dbg}, 64'd0);
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        idle_cycles(W + 6);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
